// File: rtl/mac_pkg.sv
// Shared MAC datapath constants and the guard/round/sticky bundle used by the aligner.
package mac_pkg;

    localparam int unsigned MANT_W  = 32;
    localparam int unsigned SHAMT_W = 8;
    // Guard and round bits appended below the mantissa LSB before shifting.
    localparam int unsigned GRS_W   = 2;

    typedef struct packed {
        logic grd;
        logic rnd;
        logic sticky;
    } grs_t;

endpackage

// File: rtl/mant_align_shifter_if.sv
// Valid/ready bus of the mantissa aligner: input beat side and aligned output side.
interface mant_align_shifter_if
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = MANT_W,
    parameter int unsigned SHW   = SHAMT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [SHW-1:0]   in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic             out_grd;
    logic             out_rnd;
    logic             out_sticky;
    logic             out_zero;

    // Producer of beats / consumer of aligned results.
    modport master (
        output in_valid, in_mant, in_shamt, out_ready,
        input  in_ready, out_valid, out_mant, out_grd, out_rnd, out_sticky, out_zero
    );

    // The aligner itself.
    modport slave (
        input  in_valid, in_mant, in_shamt, out_ready,
        output in_ready, out_valid, out_mant, out_grd, out_rnd, out_sticky, out_zero
    );

endinterface

// File: rtl/align_stage.sv
// One registered right-shift slice of the aligner. Shifts by sel_i*GRAN, folds the
// bits it drops into sticky and flags an all-zero result. Optional sticky tracking
// is compiled in with ALIGN_STICKY_EN.
module align_stage #(
    parameter int unsigned VW   = 34,
    parameter int unsigned GRAN = 1,
    parameter int unsigned SELW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_d_i,
    input  logic          adv_i,
    input  logic [VW-1:0] vec_i,
    input  logic [SELW-1:0] sel_i,
    input  logic          sat_i,
    input  logic          zero_i,
`ifdef ALIGN_STICKY_EN
    input  logic          sticky_i,
    output logic          sticky_o,
`endif
    output logic          valid_o,
    output logic [VW-1:0] vec_o,
    output logic          zero_o
);

    localparam int unsigned AMT_W = SELW + $clog2(GRAN);

    logic [AMT_W-1:0] amt;
    logic [VW-1:0]    shifted;
    logic [VW-1:0]    vec_d, vec_q;
    logic             zero_d, zero_q;
    logic             valid_q;
`ifdef ALIGN_STICKY_EN
    logic [VW-1:0]    lost;
    logic             sticky_d, sticky_q;
`endif

    // Shift datapath; a saturated shift clears the vector and loses every input bit.
    always_comb begin
        amt     = AMT_W'(sel_i) * AMT_W'(GRAN);
        shifted = vec_i >> amt;
        vec_d   = sat_i ? '0 : shifted;
`ifdef ALIGN_STICKY_EN
        lost     = vec_i ^ (shifted << amt);
        sticky_d = sticky_i | (sat_i ? (|vec_i) : (|lost));
        zero_d   = zero_i | ((vec_d == '0) && !sticky_d);
`else
        zero_d   = zero_i | (vec_d == '0);
`endif
    end

    // Stage valid flag: the only control state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= 1'b0;
        else        valid_q <= valid_d_i;
    end

    // Data registers load only when the stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            zero_q <= 1'b0;
`ifdef ALIGN_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else if (adv_i) begin
            vec_q  <= vec_d;
            zero_q <= zero_d;
`ifdef ALIGN_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign vec_o   = vec_q;
    assign zero_o  = zero_q;
`ifdef ALIGN_STICKY_EN
    assign sticky_o = sticky_q;
`endif

endmodule

// File: rtl/mant_align_shifter.sv
// Two-stage mantissa right-shift aligner with guard/round/sticky generation.
// S1 does the byte-granular coarse shift and saturation, S2 the 0..7 fine shift.
// Define ALIGN_STICKY_EN to build sticky tracking; otherwise out_sticky is 0.
module mant_align_shifter
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = MANT_W,
    parameter int unsigned SHW   = SHAMT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mant_align_shifter_if.slave  bus
);

    localparam int unsigned VW       = WIDTH + GRS_W;
    localparam int unsigned FINE_W   = 3;
    // Coarse field spans every non-saturating shift, including WIDTH and WIDTH+1.
    localparam int unsigned COARSE_W = $clog2(VW) - FINE_W;

    logic              s1_valid, s2_valid;
    logic              s1_valid_d, s2_valid_d;
    logic              s2_adv, accept, in_ready_c, sat_c;
    logic [VW-1:0]     s1_vec, s2_vec;
    logic              s1_zero, s2_zero;
    logic [FINE_W-1:0] fine_d, fine_q;
    grs_t              s2_grs;
`ifdef ALIGN_STICKY_EN
    logic              s1_sticky, s2_sticky;
`endif

    // Handshake and stage-valid next state; in_ready sees out_ready combinationally.
    always_comb begin
        s2_adv     = s1_valid && (!s2_valid || bus.out_ready);
        in_ready_c = !s1_valid || s2_adv;
        accept     = bus.in_valid && in_ready_c;
        s1_valid_d = accept || (s1_valid && !s2_adv);
        s2_valid_d = s2_adv || (s2_valid && !bus.out_ready);
        sat_c      = bus.in_shamt >= SHW'(VW);
        fine_d     = bus.in_shamt[FINE_W-1:0];
    end

    // Fine shift amount travels alongside the S1 data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      fine_q <= '0;
        else if (accept) fine_q <= fine_d;
    end

    align_stage #(.VW(VW), .GRAN(8), .SELW(COARSE_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_d_i (s1_valid_d),
        .adv_i     (accept),
        .vec_i     ({bus.in_mant, {GRS_W{1'b0}}}),
        .sel_i     (bus.in_shamt[FINE_W +: COARSE_W]),
        .sat_i     (sat_c),
        .zero_i    (1'b0),
`ifdef ALIGN_STICKY_EN
        .sticky_i  (1'b0),
        .sticky_o  (s1_sticky),
`endif
        .valid_o   (s1_valid),
        .vec_o     (s1_vec),
        .zero_o    (s1_zero)
    );

    align_stage #(.VW(VW), .GRAN(1), .SELW(FINE_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_d_i (s2_valid_d),
        .adv_i     (s2_adv),
        .vec_i     (s1_vec),
        .sel_i     (fine_q),
        .sat_i     (1'b0),
        .zero_i    (s1_zero),
`ifdef ALIGN_STICKY_EN
        .sticky_i  (s1_sticky),
        .sticky_o  (s2_sticky),
`endif
        .valid_o   (s2_valid),
        .vec_o     (s2_vec),
        .zero_o    (s2_zero)
    );

    // Split the S2 vector's low bits into the rounder's GRS bundle.
    always_comb begin
        s2_grs.grd = s2_vec[1];
        s2_grs.rnd = s2_vec[0];
`ifdef ALIGN_STICKY_EN
        s2_grs.sticky = s2_sticky;
`else
        s2_grs.sticky = 1'b0;
`endif
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = s2_valid;
    assign bus.out_mant   = s2_vec[VW-1:GRS_W];
    assign bus.out_grd    = s2_grs.grd;
    assign bus.out_rnd    = s2_grs.rnd;
    assign bus.out_sticky = s2_grs.sticky;
    assign bus.out_zero   = s2_zero;

endmodule

// File: tb/tb_mant_align_shifter.sv
// Directed bench for mant_align_shifter; expectations follow ALIGN_STICKY_EN.
module tb_mant_align_shifter;

`ifdef ALIGN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mant_align_shifter_if #(.WIDTH(32), .SHW(8)) bus ();

    mant_align_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if ({bus.out_mant, bus.out_grd, bus.out_rnd, bus.out_sticky, bus.out_zero} !== 36'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h %b%b%b%b want 0", bus.out_mant,
                     bus.out_grd, bus.out_rnd, bus.out_sticky, bus.out_zero);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
    endtask

    // Single beat with out_ready high: checks acceptance, 2-cycle latency and result.
    task automatic run_vec(input string name, input logic [31:0] m, input logic [7:0] sh,
                           input logic [31:0] e_m, input logic e_g, input logic e_r,
                           input logic e_s, input logic e_z_st, input logic e_z_nost);
        logic e_ss, e_z;
        int   n;
        e_ss = STICKY ? e_s : 1'b0;
        e_z  = STICKY ? e_z_st : e_z_nost;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mant   = m;
        bus.in_shamt  = sh;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b want 1", name, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 2", name, n);
        end
        checks++;
        if ({bus.out_mant, bus.out_grd, bus.out_rnd, bus.out_sticky, bus.out_zero} !==
            {e_m, e_g, e_r, e_ss, e_z}) begin
            errors++;
            $display("FAIL %s_data: got mant=%h g=%b r=%b s=%b z=%b want mant=%h g=%b r=%b s=%b z=%b",
                     name, bus.out_mant, bus.out_grd, bus.out_rnd, bus.out_sticky, bus.out_zero,
                     e_m, e_g, e_r, e_ss, e_z);
        end
        tick();
    endtask

    task automatic test_basic();
        run_vec("msb_noshift", 32'h8000_0000, 8'd0,  32'h8000_0000, 0, 0, 0, 0, 0);
        run_vec("f_shift3",    32'h0000_000F, 8'd3,  32'h0000_0001, 1, 1, 1, 0, 0);
        run_vec("seven_sh2",   32'h0000_0007, 8'd2,  32'h0000_0001, 1, 1, 0, 0, 0);
        run_vec("five_sh4",    32'h0000_0005, 8'd4,  32'h0000_0000, 0, 1, 1, 0, 0);
        run_vec("msb_sh31",    32'h8000_0000, 8'd31, 32'h0000_0001, 0, 0, 0, 0, 0);
    endtask

    task automatic test_boundary();
        run_vec("sh_width",    32'h8000_0001, 8'd32,  32'h0, 1, 0, 1, 0, 0);
        run_vec("sh_width_p1", 32'h8000_0001, 8'd33,  32'h0, 0, 1, 1, 0, 0);
        run_vec("sh_sat34",    32'hFFFF_FFFF, 8'd34,  32'h0, 0, 0, 1, 0, 1);
        run_vec("sh_sat200",   32'h0000_0001, 8'd200, 32'h0, 0, 0, 1, 0, 1);
        run_vec("sh_sat255",   32'h8000_0000, 8'd255, 32'h0, 0, 0, 1, 0, 1);
        run_vec("zero_in",     32'h0000_0000, 8'd5,   32'h0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] m  [4] = '{32'hDEAD_BEEF, 32'h0000_0100, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [7:0]  sh [4] = '{8'd16, 8'd8, 8'd31, 8'd1};
        logic [31:0] e  [4] = '{32'h0000_DEAD, 32'h0000_0001, 32'h0000_0001, 32'h2000_0000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_mant  = m[i];
                bus.in_shamt = sh[i];
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_mant !== e[i-1]) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v=%b mant=%h want v=1 mant=%h",
                             i - 1, bus.out_valid, bus.out_mant, e[i-1]);
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle[%0d]: got v=%b want 0", i, bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mant   = 32'h1234_5678;
        bus.in_shamt  = 8'd4;
        tick();
        bus.in_mant   = 32'hAAAA_0000;
        bus.in_shamt  = 8'd8;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept: got in_ready=%b want 1", bus.in_ready);
        end
        tick();
        bus.in_mant  = 32'h0000_FFFF;
        bus.in_shamt = 8'd0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_mant !== 32'h0123_4567) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got rdy=%b v=%b mant=%h want rdy=0 v=1 mant=01234567",
                         k, bus.in_ready, bus.out_valid, bus.out_mant);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_mant !== 32'h00AA_AA00) begin
            errors++;
            $display("FAIL bp_beat2: got v=%b mant=%h want v=1 mant=00aaaa00", bus.out_valid, bus.out_mant);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_mant !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL bp_beat3: got v=%b mant=%h want v=1 mant=0000ffff", bus.out_valid, bus.out_mant);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midop();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mant   = 32'h1111_1111;
        bus.in_shamt  = 8'd0;
        tick();
        bus.in_mant   = 32'h2222_2222;
        tick();
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_mant !== 32'h1111_1111) begin
            errors++;
            $display("FAIL rst_mid_full: got v=%b mant=%h want v=1 mant=11111111", bus.out_valid, bus.out_mant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_mant !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%b mant=%h want v=0 mant=0", bus.out_valid, bus.out_mant);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale[%0d]: got v=%b mant=%h want v=0", k, bus.out_valid, bus.out_mant);
            end
            tick();
        end
        run_vec("post_reset", 32'h0000_0F00, 8'd8, 32'h0000_000F, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
